// File: rtl/dsi_hs_lanes_ctrl.sv
// DSI HS burst sequencer: brings up the HS clock lane, starts LANES data lanes,
// streams LANES bytes per cycle from the packet assembler, then trails data and clock lanes.
module dsi_hs_lanes_ctrl #(
  parameter int LANES           = 4,
  parameter int CLK_PRE_CYCLES  = 4,
  parameter int CLK_POST_CYCLES = 4,
  parameter int WAIT_TIMEOUT    = 64
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  input  logic                 i_clk_continuous,
  input  logic [8*LANES-1:0]   i_pkt_data,
  input  logic                 i_pkt_valid,
  input  logic                 i_pkt_last,
  output logic                 o_pkt_ready,
  output logic                 o_clk_start_rqst,
  output logic                 o_clk_fin_rqst,
  input  logic                 i_clk_data_rqst,
  input  logic                 i_clk_fin_ack,
  output logic [LANES-1:0]     o_lane_start_rqst,
  output logic [LANES-1:0]     o_lane_fin_rqst,
  output logic [8*LANES-1:0]   o_lane_data,
  input  logic [LANES-1:0]     i_lane_data_rqst,
  input  logic [LANES-1:0]     i_lane_fin_ack,
  output logic                 o_busy,
  output logic                 o_err_underflow,
  output logic                 o_err_timeout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLK_START,
    S_CLK_PRE,
    S_DATA_START,
    S_DATA_SYNC,
    S_DATA_ACTIVE,
    S_DATA_FIN,
    S_CLK_POST,
    S_CLK_FIN,
    S_HOLD
  } state_t;

  localparam logic [7:0] PRE_LOAD  = 8'(CLK_PRE_CYCLES - 1);
  localparam logic [7:0] POST_LOAD = 8'(CLK_POST_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [7:0]       r_wait_cnt;
  logic [LANES-1:0] r_fin_cap;
  logic             r_cont;
  logic             r_clk_run;
  logic             r_clk_start_rqst;
  logic             r_clk_fin_rqst;
  logic [LANES-1:0] r_lane_start_rqst;
  logic             r_busy;
  logic             r_err_underflow;
  logic             r_err_timeout;

  state_t           w_state_next;
  logic [7:0]       w_cnt_next;
  logic [LANES-1:0] w_fin_cap_next;
  logic             w_cont_next;
  logic             w_clk_run_next;
  logic             w_err_underflow_next;
  logic             w_err_timeout_next;
  logic             w_timeout;
  logic             w_pkt_ready;
  logic             w_byte_en;
  logic             w_fin_en;
  logic             w_slot;
  logic             w_all_ack;
  logic             w_wait_expired;
  logic             w_wait_state;

  assign w_slot         = &i_lane_data_rqst;
  assign w_all_ack      = &(r_fin_cap | i_lane_fin_ack);
  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_wait_state   = (r_state == S_CLK_START) || (r_state == S_DATA_SYNC) ||
                          (r_state == S_DATA_FIN)  || (r_state == S_CLK_FIN);

  always_comb begin
    w_state_next         = r_state;
    w_cnt_next           = r_cnt;
    w_fin_cap_next       = r_fin_cap;
    w_cont_next          = r_cont;
    w_clk_run_next       = r_clk_run;
    w_err_underflow_next = r_err_underflow;
    w_err_timeout_next   = r_err_timeout;
    w_timeout            = 1'b0;
    w_pkt_ready          = 1'b0;
    w_byte_en            = 1'b0;
    w_fin_en             = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Continuous mode withdrawn while the clock lane is still up: trail it without a packet
        if (!i_clk_continuous && r_clk_run) begin
          w_state_next = S_CLK_POST;
          w_cnt_next   = POST_LOAD;
          w_cont_next  = 1'b0;
        end else if (i_pkt_valid) begin
          w_err_underflow_next = 1'b0;
          w_err_timeout_next   = 1'b0;
          w_cont_next          = i_clk_continuous;
          if (i_clk_data_rqst && i_clk_continuous) begin
            w_state_next = S_DATA_START;
          end else begin
            w_state_next = S_CLK_START;
          end
        end
      end

      S_CLK_START: begin
        if (i_clk_data_rqst) begin
          w_state_next   = S_CLK_PRE;
          w_cnt_next     = PRE_LOAD;
          w_clk_run_next = 1'b1;
        end else begin
          w_timeout = w_wait_expired;
        end
      end

      S_CLK_PRE: begin
        if (r_cnt == 8'd0) begin
          w_state_next = S_DATA_START;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end

      S_DATA_START: begin
        w_state_next = S_DATA_SYNC;
      end

      S_DATA_SYNC: begin
        if (w_slot) begin
          w_state_next = S_DATA_ACTIVE;
        end else begin
          w_timeout = w_wait_expired;
        end
      end

      S_DATA_ACTIVE: begin
        if (w_slot) begin
          w_pkt_ready = 1'b1;
          if (i_pkt_valid) begin
            w_byte_en = 1'b1;
            // Lanes sample fin together with their final byte
            if (i_pkt_last) begin
              w_fin_en       = 1'b1;
              w_state_next   = S_DATA_FIN;
              w_fin_cap_next = r_fin_cap | i_lane_fin_ack;
            end
          end else begin
            w_err_underflow_next = 1'b1;
          end
        end
      end

      S_DATA_FIN: begin
        if (w_all_ack) begin
          w_fin_cap_next = '0;
          w_cnt_next     = POST_LOAD;
          w_state_next   = r_cont ? S_IDLE : S_CLK_POST;
        end else begin
          w_fin_cap_next = r_fin_cap | i_lane_fin_ack;
          w_timeout      = w_wait_expired;
        end
      end

      S_CLK_POST: begin
        if (r_cnt == 8'd0) begin
          w_state_next = S_CLK_FIN;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end

      S_CLK_FIN: begin
        if (i_clk_fin_ack) begin
          w_state_next   = S_HOLD;
          w_clk_run_next = 1'b0;
        end else begin
          w_timeout = w_wait_expired;
        end
      end

      S_HOLD: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort drops every request by returning straight to IDLE
    if (w_timeout) begin
      w_state_next       = S_IDLE;
      w_err_timeout_next = 1'b1;
      w_clk_run_next     = 1'b0;
      w_fin_cap_next     = '0;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= S_IDLE;
      r_cnt             <= 8'd0;
      r_wait_cnt        <= 8'd0;
      r_cont            <= 1'b0;
      r_clk_run         <= 1'b0;
      r_clk_start_rqst  <= 1'b0;
      r_clk_fin_rqst    <= 1'b0;
      r_lane_start_rqst <= '0;
      r_busy            <= 1'b0;
      r_err_underflow   <= 1'b0;
      r_err_timeout     <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_cnt             <= w_cnt_next;
      r_cont            <= w_cont_next;
      r_clk_run         <= w_clk_run_next;
      r_clk_start_rqst  <= (w_state_next == S_CLK_START);
      r_clk_fin_rqst    <= (w_state_next == S_CLK_FIN);
      r_lane_start_rqst <= {LANES{w_state_next == S_DATA_START}};
      r_busy            <= (w_state_next != S_IDLE);
      r_err_underflow   <= w_err_underflow_next;
      r_err_timeout     <= w_err_timeout_next;
      if (w_state_next != r_state) begin
        r_wait_cnt <= 8'd0;
      end else if (w_wait_state) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_fin_cap[gi] <= 1'b0;
      end else begin
        r_fin_cap[gi] <= w_fin_cap_next[gi];
      end
    end

    assign o_lane_data[8*gi +: 8] = w_byte_en ? i_pkt_data[8*gi +: 8] : 8'h00;
    assign o_lane_fin_rqst[gi]    = w_fin_en;
  end

  assign o_pkt_ready       = w_pkt_ready;
  assign o_clk_start_rqst  = r_clk_start_rqst;
  assign o_clk_fin_rqst    = r_clk_fin_rqst;
  assign o_lane_start_rqst = r_lane_start_rqst;
  assign o_busy            = r_busy;
  assign o_err_underflow   = r_err_underflow;
  assign o_err_timeout     = r_err_timeout;

endmodule

// File: tb/tb_dsi_hs_lanes_ctrl.sv
// Bench for dsi_hs_lanes_ctrl: behavioural clock/data lane models, a beat scoreboard
// and an event trace used for the sequencing intervals.
module tb_dsi_hs_lanes_ctrl;

  localparam int LANES = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_continuous = 1'b0;
  logic [31:0] pkt_data = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_last = 1'b0;
  logic        pkt_ready;
  logic        clk_start_rqst, clk_fin_rqst;
  logic        clk_data_rqst = 1'b0;
  logic        clk_fin_ack = 1'b0;
  logic [3:0]  lane_start_rqst, lane_fin_rqst;
  logic [31:0] lane_data;
  logic [3:0]  lane_data_rqst = '0;
  logic [3:0]  lane_fin_ack = '0;
  logic        busy, err_underflow, err_timeout;

  dsi_hs_lanes_ctrl #(
    .LANES(LANES), .CLK_PRE_CYCLES(4), .CLK_POST_CYCLES(4), .WAIT_TIMEOUT(64)
  ) dut (
    .i_clk_sys(clk_sys), .i_rst_n(rst_n), .i_clk_continuous(clk_continuous),
    .i_pkt_data(pkt_data), .i_pkt_valid(pkt_valid), .i_pkt_last(pkt_last),
    .o_pkt_ready(pkt_ready), .o_clk_start_rqst(clk_start_rqst), .o_clk_fin_rqst(clk_fin_rqst),
    .i_clk_data_rqst(clk_data_rqst), .i_clk_fin_ack(clk_fin_ack),
    .o_lane_start_rqst(lane_start_rqst), .o_lane_fin_rqst(lane_fin_rqst),
    .o_lane_data(lane_data), .i_lane_data_rqst(lane_data_rqst), .i_lane_fin_ack(lane_fin_ack),
    .o_busy(busy), .o_err_underflow(err_underflow), .o_err_timeout(err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [31:0] data;
    logic        fin;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  bit model_rst = 1'b0;
  bit clk_dead = 1'b0;
  bit stagger = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Event trace, sampled 3 time units after each falling edge
  int   cyc = 0;
  int   n_clk_start = 0, n_lane_start = 0, n_clk_fin = 0;
  int   t_clk_start_fall = 0, t_lane_start_rise = 0, lane_start_w = 0, run_len = 0;
  int   t_clk_fin_rise = 0, t_ack = 0, t_clk_fin_ack = 0, t_busy_fall = 0;
  logic p_clk_start = 1'b0, p_lane_start = 1'b0, p_clk_fin = 1'b0, p_busy = 1'b0;

  initial forever begin
    @(negedge clk_sys);
    #3;
    cyc++;
    if (p_clk_start && !clk_start_rqst) t_clk_start_fall = cyc;
    if (!p_clk_start && clk_start_rqst) n_clk_start++;
    if (lane_start_rqst[0]) begin
      if (!p_lane_start) begin
        n_lane_start++;
        t_lane_start_rise = cyc;
        run_len = 0;
      end
      run_len++;
    end else if (p_lane_start) begin
      lane_start_w = run_len;
    end
    if (!p_clk_fin && clk_fin_rqst) begin
      n_clk_fin++;
      t_clk_fin_rise = cyc;
    end
    if (|lane_fin_ack) t_ack = cyc;
    if (clk_fin_ack) t_clk_fin_ack = cyc;
    if (p_busy && !busy) t_busy_fall = cyc;
    p_clk_start  = clk_start_rqst;
    p_lane_start = lane_start_rqst[0];
    p_clk_fin    = clk_fin_rqst;
    p_busy       = busy;
  end

  // Scoreboard monitor: one transaction per consume slot
  initial forever begin
    @(negedge clk_sys);
    #3;
    if (pkt_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_slot actual=%0h required=none", lane_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("slot cyc=%0d lane_data=%08h fin=%0h exp=%08h/%0b", cyc, lane_data, lane_fin_rqst, e.data, e.fin);
        chk("slot_data", lane_data, e.data);
        chk("slot_fin", 32'(lane_fin_rqst), 32'({4{e.fin}}));
      end
    end else if (&lane_data_rqst && rst_n) begin
      chk("noslot_data", lane_data, 32'h0);
      chk("noslot_fin", 32'(lane_fin_rqst), 32'h0);
    end
  end

  // Clock lane model: running 2 cycles after start request, fin_ack 2 cycles after fin request
  int   ck_go = 0, ck_fin = 0;
  logic ck_nxt_run = 1'b0, ck_nxt_ack = 1'b0;
  initial forever begin
    @(negedge clk_sys);
    clk_data_rqst = ck_nxt_run;
    clk_fin_ack   = ck_nxt_ack;
    #3;
    ck_nxt_ack = 1'b0;
    if (model_rst) begin
      ck_nxt_run = 1'b0;
      ck_go = 0;
      ck_fin = 0;
    end else begin
      if (clk_start_rqst && !clk_data_rqst && !clk_dead) ck_go++;
      else ck_go = 0;
      if (ck_go == 2) begin
        ck_nxt_run = 1'b1;
        ck_go = 0;
      end
      if (clk_fin_rqst) ck_fin++;
      else ck_fin = 0;
      if (ck_fin == 2) begin
        ck_nxt_ack = 1'b1;
        ck_nxt_run = 1'b0;
        ck_fin = 0;
      end
    end
  end

  // Data lane model: 2-cycle go, 2-cycle trail (lane3 +2 when staggered)
  int         ln_go = 0, ln_tr = -1;
  logic [3:0] ln_nxt_rqst = '0, ln_nxt_ack = '0;
  initial forever begin
    @(negedge clk_sys);
    lane_data_rqst = ln_nxt_rqst;
    lane_fin_ack   = ln_nxt_ack;
    #3;
    ln_nxt_ack = '0;
    if (model_rst) begin
      ln_nxt_rqst = '0;
      ln_go = 0;
      ln_tr = -1;
    end else begin
      if (lane_start_rqst[0]) ln_go = 1;
      else if (ln_go > 0) ln_go++;
      if (ln_go == 2) begin
        ln_nxt_rqst = '1;
        ln_go = 0;
      end
      if (ln_tr >= 0) begin
        ln_tr++;
        for (int k = 0; k < 4; k++) begin
          if (ln_tr == ((k == 3 && stagger) ? 4 : 2)) ln_nxt_ack[k] = 1'b1;
        end
        if (ln_tr >= 6) ln_tr = -1;
      end
      if (lane_fin_rqst[0] && (&lane_data_rqst)) begin
        ln_nxt_rqst = '0;
        ln_tr = 0;
      end
    end
  end

  logic [31:0] beat_tbl [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  // Presents beats; each accepted slot pushes its expected lane output
  task automatic send_burst(input int nbeats, input int gap_at, input int stop_after);
    int beat = 0;
    int guard = 0;
    bit gap_done = 1'b0;
    while (beat < nbeats && beat < stop_after) begin
      @(negedge clk_sys);
      if (beat == gap_at && !gap_done) begin
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_data  = 32'hDEADBEEF;
      end else begin
        pkt_valid = 1'b1;
        pkt_data  = beat_tbl[beat];
        pkt_last  = (beat == nbeats - 1);
      end
      #2;
      if (pkt_ready) begin
        if (!pkt_valid) begin
          sb_q.push_back('{32'h0, 1'b0});
          gap_done = 1'b1;
        end else begin
          sb_q.push_back('{pkt_data, pkt_last});
          beat++;
        end
      end
      guard++;
      if (guard > 500) begin
        checks++;
        errors++;
        $display("FAIL src_timeout actual=%0d beats required=%0d", beat, nbeats);
        break;
      end
    end
    @(negedge clk_sys);
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    pkt_data  = '0;
  endtask

  task automatic wait_idle(input int limit);
    bit saw = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk_sys);
      #3;
      if (busy) saw = 1'b1;
      else if (saw) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(negedge clk_sys);
    #4;
  endtask

  task automatic check_normal_seq(input string tag);
    chk({tag, "_pre_gap"}, 32'(t_lane_start_rise - t_clk_start_fall), 32'd4);
    chk({tag, "_start_width"}, 32'(lane_start_w), 32'd1);
    chk({tag, "_post_gap"}, 32'(t_clk_fin_rise - t_ack), 32'd5);
    chk({tag, "_hold_gap"}, 32'(t_busy_fall - t_clk_fin_ack), 32'd2);
    chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  int s_start, s_lane, s_fin, c0, n_start_hi;
  bit seen;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    chk("rst_clk_start", 32'(clk_start_rqst), 32'd0);
    chk("rst_clk_fin", 32'(clk_fin_rqst), 32'd0);
    chk("rst_lane_start", 32'(lane_start_rqst), 32'd0);
    chk("rst_lane_data", lane_data, 32'd0);
    chk("rst_errs", 32'({err_underflow, err_timeout}), 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Normal 3-beat burst
    s_start = n_clk_start;
    send_burst(3, -1, 99);
    wait_idle(200);
    check_normal_seq("basic");
    chk("basic_clk_starts", 32'(n_clk_start - s_start), 32'd1);
    chk("basic_uf", 32'(err_underflow), 32'd0);
    chk("basic_to", 32'(err_timeout), 32'd0);

    // Underflow slot mid-burst
    send_burst(3, 1, 99);
    wait_idle(200);
    check_normal_seq("uflow");
    chk("uflow_flag", 32'(err_underflow), 32'd1);

    // Clock lane never runs: timeout in CLK_START
    clk_dead = 1'b1;
    n_start_hi = 0;
    seen = 1'b0;
    @(negedge clk_sys);
    pkt_valid = 1'b1;
    pkt_last  = 1'b1;
    pkt_data  = beat_tbl[0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (seen) pkt_valid = 1'b0;
      #3;
      if (clk_start_rqst) begin
        n_start_hi++;
        seen = 1'b1;
      end
      if (err_timeout) break;
    end
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    chk("to_cycles", 32'(n_start_hi), 32'd64);
    chk("to_flag", 32'(err_timeout), 32'd1);
    chk("to_start_low", 32'(clk_start_rqst), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_uf_cleared", 32'(err_underflow), 32'd0);
    clk_dead = 1'b0;
    repeat (4) @(negedge clk_sys);

    // Continuous clock, two bursts back to back, then leave continuous mode
    clk_continuous = 1'b1;
    s_fin = n_clk_fin;
    send_burst(2, -1, 99);
    wait_idle(200);
    chk("cont_a_to_cleared", 32'(err_timeout), 32'd0);
    s_start = n_clk_start;
    s_lane  = n_lane_start;
    send_burst(2, -1, 99);
    wait_idle(200);
    chk("cont_b_no_clk_start", 32'(n_clk_start - s_start), 32'd0);
    chk("cont_b_lane_start", 32'(n_lane_start - s_lane), 32'd1);
    chk("cont_no_clk_fin", 32'(n_clk_fin - s_fin), 32'd0);
    chk("cont_sb_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk_sys);
    clk_continuous = 1'b0;
    #4;
    c0 = cyc;
    wait_idle(100);
    chk("cont_exit_fin", 32'(n_clk_fin - s_fin), 32'd1);
    chk("cont_exit_gap", 32'(t_clk_fin_rise - c0), 32'd5);

    // Lane3 fin_ack two cycles late
    stagger = 1'b1;
    send_burst(3, -1, 99);
    wait_idle(200);
    check_normal_seq("stag");
    stagger = 1'b0;

    // Reset in DATA_ACTIVE, then a fresh burst
    send_burst(3, -1, 2);
    #1;
    rst_n = 1'b0;
    model_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pkt_ready", 32'(pkt_ready), 32'd0);
    chk("arst_lane_data", lane_data, 32'd0);
    chk("arst_lane_fin", 32'(lane_fin_rqst), 32'd0);
    chk("arst_starts", 32'({clk_start_rqst, lane_start_rqst}), 32'd0);
    repeat (3) @(negedge clk_sys);
    model_rst = 1'b0;
    rst_n = 1'b1;
    s_start = n_clk_start;
    send_burst(3, -1, 99);
    wait_idle(200);
    chk("post_rst_clk_start", 32'(n_clk_start - s_start), 32'd1);
    check_normal_seq("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsi_hs_lanes_ctrl.md
Name: dsi_hs_lanes_ctrl

Overview:
Sequences one HS clock lane and LANES HS data lanes for a DSI burst. It brings the clock lane up, waits the clock-pre interval, starts the data lanes and feeds them LANES bytes per cycle from an upstream packet stream. It then finishes the data lanes, waits the clock-post interval and stops the clock lane. It sits between the packet assembler and the per-lane HS serializer front-ends: one clock-mode lane and LANES data-mode lanes.

Parameters:
LANES, 4, number of data lanes (1..4)
CLK_PRE_CYCLES, 4, clk_sys cycles from clock lane running to data lane start (1..255)
CLK_POST_CYCLES, 4, clk_sys cycles from all data fin_ack to clock lane fin request (1..255)
WAIT_TIMEOUT, 64, max cycles waiting on any lane handshake before abort (2..255)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
clk_continuous  in  1  1: clock lane stays running between bursts; sampled in IDLE
pkt_data  in  8*LANES  byte k goes to lane k (bits 8k+7:8k)
pkt_valid  in  1  upstream beat valid
pkt_last  in  1  last beat of burst
pkt_ready  out  1  beat accepted when pkt_valid&pkt_ready
clk_start_rqst  out  1  clock lane start request
clk_fin_rqst  out  1  clock lane finish request
clk_data_rqst  in  1  clock lane running
clk_fin_ack  in  1  clock lane trail done
lane_start_rqst  out  LANES  data lane start requests (all bits equal)
lane_fin_rqst  out  LANES  data lane finish requests (all bits equal)
lane_data  out  8*LANES  bytes to data lanes
lane_data_rqst  in  LANES  per-lane data request
lane_fin_ack  in  LANES  per-lane trail done
busy  out  1  high in any state other than IDLE
err_underflow  out  1  sticky; pkt_valid low in a consume slot
err_timeout  out  1  sticky; handshake timeout abort

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; sticky flags 0; fin-ack capture 0. Reset mid-burst returns to IDLE immediately, with no trail sequence.
- States: IDLE, CLK_START, CLK_PRE, DATA_START, DATA_SYNC, DATA_ACTIVE, DATA_FIN, CLK_POST, CLK_FIN, HOLD.
- IDLE: on pkt_valid, clear err_*. Go to CLK_START; go to DATA_START instead if the clock lane is already running (clk_data_rqst=1, continuous mode).
- CLK_START: clk_start_rqst=1 while in this state. Leave for CLK_PRE when clk_data_rqst=1; load the pre counter with CLK_PRE_CYCLES-1.
- CLK_PRE: decrement the counter; at 0 go to DATA_START.
- DATA_START: lane_start_rqst=all-ones for exactly 1 cycle. Go to DATA_SYNC.
- DATA_SYNC: wait for &lane_data_rqst. The first cycle it is high is the SYNC slot: no byte consumed, lane_data=0, go to DATA_ACTIVE.
- DATA_ACTIVE:
  - Every cycle with &lane_data_rqst is a consume slot; pkt_ready=1 (combinational).
  - lane_data = pkt_data when pkt_valid, else 0, and err_underflow is set.
  - When pkt_valid&pkt_last in a slot, lane_fin_rqst=all-ones in that same cycle, because lanes sample fin in their last active byte. Then go to DATA_FIN.
- DATA_FIN: per-lane sticky capture of lane_fin_ack. When all bits are captured, clear the capture and load the post counter with CLK_POST_CYCLES-1, then:
  - if clk_continuous was 1 at burst start: go to IDLE;
  - else: go to CLK_POST.
- CLK_POST: decrement the counter; at 0 go to CLK_FIN.
- CLK_FIN: clk_fin_rqst=1 until clk_fin_ack. Then go to HOLD.
- HOLD: 1 cycle, then IDLE. This guarantees the clock lane's IDLE is observed before the next start.
- Continuous mode, first burst: the clock lane is brought up via CLK_START.
- Continuous mode, cleared in IDLE with the clock running: go CLK_POST → CLK_FIN → HOLD without a packet.
- Timeout: a shared wait counter is reset on every state entry and counts in CLK_START, DATA_SYNC, DATA_FIN and CLK_FIN. At WAIT_TIMEOUT cycles: set err_timeout, force all requests to 0 and go to IDLE. pkt_ready stays 0 outside DATA_ACTIVE.
- Simultaneous events: pkt_last and an underflow cannot coincide (last requires valid). A lane_fin_ack arriving in the same cycle as DATA_FIN entry is captured.
- pkt_ready, lane_data and lane_fin_rqst are combinational from state and inputs. All other outputs are registered.

Test Plan:
- LANES=4, PRE=4, POST=4, 3-beat burst, data 0x03020100/0x07060504/0x0B0A0908, lane model with 2-cycle go and trail:
  - clk_start_rqst, then 4 cycles, then a 1-cycle lane_start_rqst;
  - SYNC slot carries no byte; lane0 receives 00,04,08;
  - lane_fin_rqst is high exactly on the 0x0B0A0908 beat;
  - after fin_acks, 4 cycles, then clk_fin_rqst; busy=0 after HOLD.
- Valid drops for 1 slot mid-burst → lane_data=0 in that slot, err_underflow=1, burst completes normally.
- Clock lane never asserts clk_data_rqst, WAIT_TIMEOUT=64 → err_timeout=1 at cycle 64 in CLK_START, clk_start_rqst=0, state IDLE.
- clk_continuous=1, two back-to-back bursts:
  - no clk_fin_rqst between them;
  - the second burst goes IDLE→DATA_START directly;
  - clearing clk_continuous in IDLE triggers the post/fin sequence.
- Lane fin_acks staggered (lane3 two cycles late) → CLK_POST entered only after lane3 ack.
- rst_n asserted during DATA_ACTIVE → all outputs 0 asynchronously; next pkt_valid starts a fresh sequence from CLK_START.
